// File: rtl/tile_scheduler_if.sv
// tile_scheduler_if: frame request plus raster and flush 4-phase handshakes between the scheduler and its clients.
interface tile_scheduler_if;
  logic       frameStart;
  logic       busy;
  logic       frameDone;
  logic       startRasterizing;
  logic       doneRasterizing;
  logic       rasterTileID;
  logic [9:0] rasterxOffset;
  logic [9:0] rasteryOffset;
  logic       startFlush;
  logic       doneFlush;
  logic       flushTileID;
  logic [9:0] flushxOffset;
  logic [9:0] flushyOffset;
  modport master (
    input  frameStart, doneRasterizing, doneFlush,
    output busy, frameDone, startRasterizing, rasterTileID, rasterxOffset, rasteryOffset,
           startFlush, flushTileID, flushxOffset, flushyOffset
  );
  modport slave (
    output frameStart, doneRasterizing, doneFlush,
    input  busy, frameDone, startRasterizing, rasterTileID, rasterxOffset, rasteryOffset,
           startFlush, flushTileID, flushxOffset, flushyOffset
  );
endinterface

// File: rtl/tile_scheduler.sv
// tile_scheduler: raster-scan tile walker feeding a rasterizer and a flusher through two ping-pong colour buffers.
module tile_scheduler #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int TILE_DIM = 8
) (
  input logic              BOARD_CLK,
  input logic              RESET,
  tile_scheduler_if.master sched
);
  localparam logic [1:0] R_IDLE = 2'd0, R_REQ = 2'd1, R_REL = 2'd2;
  localparam logic [1:0] F_IDLE = 2'd0, F_REQ = 2'd1, F_REL = 2'd2;
  localparam logic [9:0] STEP   = 10'(TILE_DIM);
  localparam logic [9:0] LAST_X = 10'(SCREEN_W - TILE_DIM);
  localparam logic [9:0] LAST_Y = 10'(SCREEN_H - TILE_DIM);
  logic [1:0] rState, fState, bufFull;
  logic [9:0] tx, ty;
  logic [9:0] bufX [2];
  logic [9:0] bufY [2];
  logic       rBuf, fBuf, lastIssued;
  logic       rGo, rDone, fGo, fDone, frameEnd;
  // frameStart counts as active so the first request rises on the accept edge
  assign rGo      = rState == R_IDLE && (sched.busy || sched.frameStart) && !lastIssued && !bufFull[rBuf];
  assign rDone    = rState == R_REQ && sched.doneRasterizing;
  assign fGo      = fState == F_IDLE && bufFull[fBuf];
  assign fDone    = fState == F_REQ && sched.doneFlush;
  assign frameEnd = sched.busy && lastIssued && bufFull == 2'b00 && rState == R_IDLE && fState == F_IDLE;
  always_ff @(posedge BOARD_CLK) begin
    if (RESET) begin
      rState                 <= R_IDLE;
      fState                 <= F_IDLE;
      bufFull                <= 2'b00;
      tx                     <= '0;
      ty                     <= '0;
      bufX                   <= '{default: '0};
      bufY                   <= '{default: '0};
      rBuf                   <= 1'b0;
      fBuf                   <= 1'b0;
      lastIssued             <= 1'b0;
      sched.busy             <= 1'b0;
      sched.frameDone        <= 1'b0;
      sched.startRasterizing <= 1'b0;
      sched.rasterTileID     <= 1'b0;
      sched.rasterxOffset    <= '0;
      sched.rasteryOffset    <= '0;
      sched.startFlush       <= 1'b0;
      sched.flushTileID      <= 1'b0;
      sched.flushxOffset     <= '0;
      sched.flushyOffset     <= '0;
    end else begin
      sched.frameDone <= frameEnd;
      if (frameEnd) begin
        sched.busy <= 1'b0;
        tx         <= '0;
        ty         <= '0;
        lastIssued <= 1'b0;
      end else if (sched.frameStart && !sched.busy) sched.busy <= 1'b1;
      if (rGo) begin
        rState                 <= R_REQ;
        sched.startRasterizing <= 1'b1;
        sched.rasterTileID     <= rBuf;
        sched.rasterxOffset    <= tx;
        sched.rasteryOffset    <= ty;
      end
      // the finished tile's origin travels with its buffer to the flusher
      if (rDone) begin
        rState                 <= R_REL;
        sched.startRasterizing <= 1'b0;
        bufFull[rBuf]          <= 1'b1;
        bufX[rBuf]             <= tx;
        bufY[rBuf]             <= ty;
        rBuf                   <= ~rBuf;
        tx                     <= tx == LAST_X ? '0 : tx + STEP;
        ty                     <= tx == LAST_X ? (ty == LAST_Y ? '0 : ty + STEP) : ty;
        lastIssued             <= tx == LAST_X && ty == LAST_Y;
      end
      if (rState == R_REL && !sched.doneRasterizing) rState <= R_IDLE;
      if (fGo) begin
        fState             <= F_REQ;
        sched.startFlush   <= 1'b1;
        sched.flushTileID  <= fBuf;
        sched.flushxOffset <= bufX[fBuf];
        sched.flushyOffset <= bufY[fBuf];
      end
      if (fDone) begin
        fState           <= F_REL;
        sched.startFlush <= 1'b0;
        bufFull[fBuf]    <= 1'b0;
        fBuf             <= ~fBuf;
      end
      if (fState == F_REL && !sched.doneFlush) fState <= F_IDLE;
    end
  end
endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
- Upstream sequencer for the tile rasterizer: walks the screen in TILE_DIM x TILE_DIM tiles, raster-scan order, one frame per request.
- Issues each tile to the rasterizer with ping-pong colour-buffer selection (rasterTileID).
- Hands each finished buffer to the tile flusher (framebuffer writer) so rasterizing tile N overlaps flushing tile N-1.
- Signals frame completion once every tile is rasterized and flushed.

Parameters:
SCREEN_W, 640, screen width in pixels; multiple of TILE_DIM, <= 1024
SCREEN_H, 480, screen height in pixels; multiple of TILE_DIM, <= 1024
TILE_DIM, 8, tile edge in pixels; power of two

Ports:
BOARD_CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
frameStart  in  1  request a frame; sampled only when idle
busy  out  1  high from frame accept until frameDone
frameDone  out  1  one-cycle pulse when the frame's last flush completes
startRasterizing  out  1  level request to rasterizer
doneRasterizing  in  1  rasterizer completion level
rasterTileID  out  1  colour buffer the rasterizer writes
rasterxOffset  out  10  tile origin x for rasterizer
rasteryOffset  out  10  tile origin y for rasterizer
startFlush  out  1  level request to flusher
doneFlush  in  1  flusher completion level
flushTileID  out  1  colour buffer the flusher reads
flushxOffset  out  10  framebuffer x of tile being flushed
flushyOffset  out  10  framebuffer y of tile being flushed

Behaviour:
- All outputs are registered. RESET: every output 0, both FSMs idle, tile counters (tx,ty)=0, rBuf=0, fBuf=0, bufFull=2'b00, frame inactive. RESET mid-operation aborts the frame immediately; no frameDone pulse is issued.
- Frame accept: frameStart sampled high with frame inactive -> frame active, busy=1 from the next edge. frameStart while busy is ignored (no queuing).
- Handshakes (raster and flush identical, 4-phase level protocol):
  - Request rises. Request, TileID and offsets hold stable until done is sampled high.
  - Request drops on the edge that samples done=1.
  - No new request until done is sampled low.
- Raster FSM states: R_IDLE, R_REQ, R_REL.
  - R_IDLE -> R_REQ when frame active, tiles remain and bufFull[rBuf]==0. startRasterizing=1, rasterTileID=rBuf, offsets=(tx,ty) from that edge. First tile's request rises on the same edge busy rises.
  - R_REQ, doneRasterizing=1: startRasterizing<=0, bufFull[rBuf]<=1, bufX/bufY[rBuf]<=(tx,ty), rBuf toggles, counter advances, -> R_REL.
  - R_REL -> R_IDLE when doneRasterizing=0.
- Counter advance: tx+=TILE_DIM. At tx==SCREEN_W-TILE_DIM, tx wraps to 0 and ty+=TILE_DIM. The last tile (SCREEN_W-TILE_DIM, SCREEN_H-TILE_DIM) sets lastIssued; no further raster requests this frame.
- Flush FSM states: F_IDLE, F_REQ, F_REL.
  - F_IDLE -> F_REQ when bufFull[fBuf]==1. startFlush=1, flushTileID=fBuf, offsets=bufX/bufY[fBuf]. Earliest: one edge after the raster done edge.
  - F_REQ, doneFlush=1: startFlush<=0, bufFull[fBuf]<=0, fBuf toggles, -> F_REL.
  - F_REL -> F_IDLE when doneFlush=0.
- Ordering: flushes occur in raster order. A buffer is never rasterized while full or being flushed. A buffer is never flushed before its raster completes.
- Simultaneous bufFull set/clear on the same edge touches different buffers and both take effect. A new raster into a buffer cleared that edge waits one cycle (R_IDLE sees the updated bit).
- Frame end: lastIssued && bufFull==0 && flush FSM in F_IDLE && raster FSM in R_IDLE -> frameDone=1 for exactly one cycle, busy<=0 on the same edge, counters reset to 0. rBuf/fBuf are not reset, so they stay equal.
- Offsets are 10-bit unsigned; no overflow within the parameter limits.

Test Plan:
- SCREEN_W=16, SCREEN_H=16, TILE_DIM=8, rasterizer model done 3 cycles after start, flusher 5 cycles -> raster offsets (0,0)ID0, (8,0)ID1, (0,8)ID0, (8,8)ID1; flush offsets in the same order with matching IDs; exactly one frameDone; busy low afterwards.
- Slow flusher (done after 40 cycles), fast rasterizer -> third raster request (ID0) does not rise until the edge after flush of (0,0) completes; startRasterizing never high while the flush of ID0 is active.
- Rasterizer holds doneRasterizing high 4 cycles after start drops -> no new startRasterizing until done is sampled low; the tile count still advances once per tile.
- frameStart pulsed again mid-frame -> ignored; exactly 4 raster requests and one frameDone.
- RESET asserted while startRasterizing=1 and startFlush=1 -> all outputs 0 next edge, no frameDone; new frameStart restarts at (0,0) with ID0.
- Default parameters, zero-latency models -> 4800 raster and 4800 flush handshakes; last flush at (632,472); frameDone once.
